// File: rtl/panel_bus_pkg.sv
// Shared definitions for the panel control write bus: arbiter state encoding
// and the default bus widths used by udp_panel_writer, ledpanel and the arbiter.
package panel_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam int PANEL_EN_W   = 8;
  localparam int PANEL_WR_W   = 4;
  localparam int PANEL_ADDR_W = 16;
  localparam int PANEL_DATA_W = 24;

  // Index width for a requester count, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/panel_bus_arbiter_if.sv
// Requester-side handshake plus the shared ctrl_* write bus and arbiter status.
// The master side drives beats; the slave side is the arbiter.
interface panel_bus_arbiter_if
  import panel_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int EN_W    = PANEL_EN_W,
  parameter int WR_W    = PANEL_WR_W,
  parameter int ADDR_W  = PANEL_ADDR_W,
  parameter int DATA_W  = PANEL_DATA_W
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*EN_W-1:0]   req_en;
  logic [NUM_REQ*WR_W-1:0]   req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdat;

  logic [EN_W-1:0]           ctrl_en;
  logic [WR_W-1:0]           ctrl_wr;
  logic [ADDR_W-1:0]         ctrl_addr;
  logic [DATA_W-1:0]         ctrl_wdat;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      timeout_pulse;

  modport master (
    output req_valid, req_last, req_en, req_wr, req_addr, req_wdat,
    input  req_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat,
    input  grant_id, busy, timeout_pulse
  );

  modport slave (
    input  req_valid, req_last, req_en, req_wr, req_addr, req_wdat,
    output req_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat,
    output grant_id, busy, timeout_pulse
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[wrap_idx(ptr, k)]) begin
        any    = 1'b1;
        winner = wrap_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/panel_bus_arbiter.sv
// Round-robin, burst-locking arbiter for the panel control write bus with
// optional write pacing and a stall timeout that revokes a stuck grant.
module panel_bus_arbiter
  import panel_bus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int EN_W       = PANEL_EN_W,
  parameter int WR_W       = PANEL_WR_W,
  parameter int ADDR_W     = PANEL_ADDR_W,
  parameter int DATA_W     = PANEL_DATA_W,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 1024
) (
  input logic                clock,
  input logic                resetn,
  panel_bus_arbiter_if.slave bus
);

  localparam int ID_W     = id_width(NUM_REQ);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int STALL_W  = $clog2(TIMEOUT);

  arb_state_t          state;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic [GAP_W-1:0]    gap_cnt;
  logic [STALL_W-1:0]  stall_cnt;
  logic                burst_open;
  logic                timeout_q;
  logic                own_valid;
  logic                own_last;
  logic                accept;

  logic [EN_W-1:0]     ctrl_en_p1;
  logic [WR_W-1:0]     ctrl_wr_p1;
  logic [ADDR_W-1:0]   ctrl_addr_p1;
  logic [DATA_W-1:0]   ctrl_wdat_p1;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + ID_W'(1);
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .winner (pick_id),
    .any    (pick_any)
  );

  assign own_valid = bus.req_valid[owner];
  assign own_last  = bus.req_last[owner];
  // Ready depends only on state and owner so requesters may wait on it safely.
  assign bus.req_ready = (state == ST_GRANT) ? (NUM_REQ'(1) << owner) : '0;
  assign accept        = (state == ST_GRANT) && own_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      gap_cnt      <= '0;
      stall_cnt    <= '0;
      burst_open   <= 1'b0;
      timeout_q    <= 1'b0;
      ctrl_en_p1   <= '0;
      ctrl_wr_p1   <= '0;
      ctrl_addr_p1 <= '0;
      ctrl_wdat_p1 <= '0;
    end else begin
      // p1: accepted beat is driven for exactly one cycle, zeros otherwise
      timeout_q    <= 1'b0;
      ctrl_en_p1   <= '0;
      ctrl_wr_p1   <= '0;
      ctrl_addr_p1 <= '0;
      ctrl_wdat_p1 <= '0;
      if (accept) begin
        ctrl_en_p1   <= bus.req_en[int'(owner)*EN_W +: EN_W];
        ctrl_wr_p1   <= bus.req_wr[int'(owner)*WR_W +: WR_W];
        ctrl_addr_p1 <= bus.req_addr[int'(owner)*ADDR_W +: ADDR_W];
        ctrl_wdat_p1 <= bus.req_wdat[int'(owner)*DATA_W +: DATA_W];
      end

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner      <= pick_id;
            burst_open <= 1'b1;
            stall_cnt  <= '0;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (accept) begin
            stall_cnt <= '0;
            gap_cnt   <= '0;
            if (own_last) begin
              rr_ptr     <= next_id(owner);
              burst_open <= 1'b0;
              state      <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else if (GAP_CYCLES > 0) begin
              state <= ST_GAP;
            end
          end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
            // This stalled cycle would reach TIMEOUT: release the bus.
            rr_ptr     <= next_id(owner);
            burst_open <= 1'b0;
            stall_cnt  <= '0;
            timeout_q  <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            gap_cnt <= '0;
            state   <= burst_open ? ST_GRANT : ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ctrl_en       = ctrl_en_p1;
  assign bus.ctrl_wr       = ctrl_wr_p1;
  assign bus.ctrl_addr     = ctrl_addr_p1;
  assign bus.ctrl_wdat     = ctrl_wdat_p1;
  assign bus.grant_id      = owner;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_panel_bus_arbiter.sv
// Bench for panel_bus_arbiter: directed scenarios on a 3-requester / no-gap
// instance and a 2-requester / 3-cycle-gap instance, plus randomized traffic.
module tb_panel_bus_arbiter;
  import panel_bus_pkg::*;

  typedef struct packed {
    logic [7:0]  en;
    logic [3:0]  wr;
    logic [15:0] a;
    logic [23:0] d;
    logic        l;
  } beat_t;

  logic clock = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;
  beat_t rq [3][$];

  always #5 clock = ~clock;

  panel_bus_arbiter_if #(.NUM_REQ(3)) ifa ();
  panel_bus_arbiter_if #(.NUM_REQ(2)) ifb ();

  panel_bus_arbiter #(.NUM_REQ(3), .GAP_CYCLES(0), .TIMEOUT(8)) dut_a (
    .clock (clock), .resetn (resetn), .bus (ifa.slave));
  panel_bus_arbiter #(.NUM_REQ(2), .GAP_CYCLES(3), .TIMEOUT(8)) dut_b (
    .clock (clock), .resetn (resetn), .bus (ifb.slave));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clr_inputs();
    ifa.req_valid = '0; ifa.req_last = '0; ifa.req_en = '0;
    ifa.req_wr = '0; ifa.req_addr = '0; ifa.req_wdat = '0;
    ifb.req_valid = '0; ifb.req_last = '0; ifb.req_en = '0;
    ifb.req_wr = '0; ifb.req_addr = '0; ifb.req_wdat = '0;
  endtask

  task automatic set_a(input int i, input bit v, input bit l,
                       input logic [15:0] a, input logic [23:0] d);
    ifa.req_valid[i] = v;
    ifa.req_last[i]  = l;
    ifa.req_en[i*8 +: 8]    = 8'hFF;
    ifa.req_wr[i*4 +: 4]    = 4'h1;
    ifa.req_addr[i*16 +: 16] = a;
    ifa.req_wdat[i*24 +: 24] = d;
  endtask

  task automatic set_b(input int i, input bit v, input bit l,
                       input logic [15:0] a, input logic [23:0] d);
    ifb.req_valid[i] = v;
    ifb.req_last[i]  = l;
    ifb.req_en[i*8 +: 8]    = 8'hFF;
    ifb.req_wr[i*4 +: 4]    = 4'h1;
    ifb.req_addr[i*16 +: 16] = a;
    ifb.req_wdat[i*24 +: 24] = d;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    clr_inputs();
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  function automatic int rr_choose(input logic [2:0] v, input int ptr);
    for (int k = 0; k < 3; k++)
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    clr_inputs();
    cyc();
    n_cmp++;
    if ({ifa.ctrl_en, ifa.ctrl_wr, ifa.ctrl_addr, ifa.ctrl_wdat} !== 52'h0) begin
      n_err++; $display("FAIL reset_ctrl_a: got %h want 0", {ifa.ctrl_en, ifa.ctrl_addr, ifa.ctrl_wdat});
    end
    n_cmp++;
    if ({ifa.req_ready, ifa.grant_id, ifa.busy, ifa.timeout_pulse} !== 7'h0) begin
      n_err++; $display("FAIL reset_status_a: got %b want 0", {ifa.req_ready, ifa.grant_id, ifa.busy, ifa.timeout_pulse});
    end
    n_cmp++;
    if ({ifb.ctrl_en, ifb.ctrl_wr, ifb.ctrl_addr, ifb.ctrl_wdat} !== 52'h0) begin
      n_err++; $display("FAIL reset_ctrl_b: got %h want 0", {ifb.ctrl_en, ifb.ctrl_addr, ifb.ctrl_wdat});
    end
    n_cmp++;
    if ({ifb.req_ready, ifb.grant_id, ifb.busy, ifb.timeout_pulse} !== 5'h0) begin
      n_err++; $display("FAIL reset_status_b: got %b want 0", {ifb.req_ready, ifb.grant_id, ifb.busy, ifb.timeout_pulse});
    end
  endtask

  task automatic test_burst();
    logic [15:0] a;
    apply_reset();
    set_a(0, 1, 0, 16'h0010, 24'hFF0000);
    cyc();
    n_cmp++;
    if (ifa.req_ready !== 3'b001 || ifa.grant_id !== 2'd0) begin
      n_err++; $display("FAIL burst_grant: got ready %b id %0d want 001 id 0", ifa.req_ready, ifa.grant_id);
    end
    for (int b = 0; b < 3; b++) begin
      cyc();
      a = 16'h0010 + 16'(b);
      n_cmp++;
      if (ifa.ctrl_en !== 8'hFF || ifa.ctrl_addr !== a || ifa.ctrl_wdat !== 24'hFF0000) begin
        n_err++; $display("FAIL burst_beat%0d: got en %h addr %h wdat %h want ff %h ff0000",
                          b, ifa.ctrl_en, ifa.ctrl_addr, ifa.ctrl_wdat, a);
      end
      n_cmp++;
      if (ifa.busy !== (b < 2) || ifa.grant_id !== 2'd0) begin
        n_err++; $display("FAIL burst_busy%0d: got busy %b id %0d want %b id 0", b, ifa.busy, ifa.grant_id, (b < 2));
      end
      if (b < 2) set_a(0, 1, (b == 1), a + 16'h1, 24'hFF0000);
      else set_a(0, 0, 0, 16'h0, 24'h0);
    end
    cyc();
    n_cmp++;
    if (ifa.ctrl_en !== 8'h00) begin
      n_err++; $display("FAIL burst_strobe_end: got en %h want 00", ifa.ctrl_en);
    end
  endtask

  task automatic test_alternation();
    int beat_i[2];
    int seq[$];
    int last_t, nburst, acc;
    apply_reset();
    beat_i = '{0, 0};
    last_t = -1;
    nburst = 0;
    for (int i = 0; i < 2; i++) set_a(i, 1, 0, 16'(i * 256), 24'(i + 1));
    for (int t = 0; t < 40 && nburst < 4; t++) begin
      acc = -1;
      for (int i = 0; i < 2; i++) if (ifa.req_ready[i] && ifa.req_valid[i]) acc = i;
      cyc();
      if (acc >= 0) begin
        if (beat_i[acc] % 2 == 0) begin
          seq.push_back(acc);
          if (last_t >= 0) begin
            n_cmp++;
            if (t - last_t != 2) begin
              n_err++; $display("FAIL alt_idle_gap: got %0d cycles want 2", t - last_t);
            end
          end
        end else begin
          last_t = t;
          nburst++;
        end
        beat_i[acc]++;
        set_a(acc, 1, (beat_i[acc] % 2 == 1), 16'(acc * 256 + beat_i[acc]), 24'(acc + 1));
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (k >= seq.size()) begin
        n_err++; $display("FAIL alt_order%0d: got no burst want req%0d", k, k % 2);
      end else if (seq[k] != k % 2) begin
        n_err++; $display("FAIL alt_order%0d: got req%0d want req%0d", k, seq[k], k % 2);
      end
    end
    clr_inputs();
  endtask

  task automatic test_gap();
    int guard, rz, ez;
    apply_reset();
    set_b(1, 1, 0, 16'h0100, 24'h00FF00);
    guard = 0;
    while (ifb.req_ready[1] !== 1'b1 && guard < 10) begin cyc(); guard++; end
    n_cmp++;
    if (guard >= 10) begin
      n_err++; $display("FAIL gap_grant: got no ready want ready within 10 cycles");
    end
    cyc();
    n_cmp++;
    if (ifb.ctrl_en !== 8'hFF || ifb.ctrl_addr !== 16'h0100) begin
      n_err++; $display("FAIL gap_beat0: got en %h addr %h want ff 0100", ifb.ctrl_en, ifb.ctrl_addr);
    end
    set_b(1, 1, 1, 16'h0101, 24'h00FF00);
    rz = 0; ez = 0; guard = 0;
    while (ifb.req_ready[1] !== 1'b1 && guard < 20) begin
      rz++;
      cyc();
      guard++;
      if (ifb.ctrl_en === 8'h00) ez++;
    end
    n_cmp++;
    if (rz != 3 || ez != 3) begin
      n_err++; $display("FAIL gap_len: got ready0 %0d en0 %0d want 3 3", rz, ez);
    end
    cyc();
    n_cmp++;
    if (ifb.ctrl_en !== 8'hFF || ifb.ctrl_addr !== 16'h0101 || ifb.busy !== 1'b1) begin
      n_err++; $display("FAIL gap_beat1: got en %h addr %h busy %b want ff 0101 1", ifb.ctrl_en, ifb.ctrl_addr, ifb.busy);
    end
    set_b(1, 0, 0, 16'h0, 24'h0);
    repeat (3) cyc();
    n_cmp++;
    if (ifb.busy !== 1'b0) begin
      n_err++; $display("FAIL gap_release: got busy %b want 0", ifb.busy);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    set_a(0, 1, 0, 16'h0030, 24'h0000FF);
    set_a(1, 1, 1, 16'h0040, 24'h00FF00);
    cyc();
    cyc();
    n_cmp++;
    if (ifa.ctrl_en !== 8'hFF || ifa.grant_id !== 2'd0) begin
      n_err++; $display("FAIL to_first_beat: got en %h id %0d want ff 0", ifa.ctrl_en, ifa.grant_id);
    end
    set_a(0, 0, 0, 16'h0, 24'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_cmp++;
      if (ifa.timeout_pulse !== (k == 8) || ifa.ctrl_en !== 8'h00 || ifa.busy !== (k < 8)) begin
        n_err++; $display("FAIL to_stall%0d: got pulse %b en %h busy %b want %b 00 %b",
                          k, ifa.timeout_pulse, ifa.ctrl_en, ifa.busy, (k == 8), (k < 8));
      end
    end
    cyc();
    n_cmp++;
    if (ifa.grant_id !== 2'd1 || ifa.req_ready !== 3'b010 || ifa.timeout_pulse !== 1'b0) begin
      n_err++; $display("FAIL to_regrant: got id %0d ready %b pulse %b want 1 010 0",
                        ifa.grant_id, ifa.req_ready, ifa.timeout_pulse);
    end
    clr_inputs();
  endtask

  task automatic test_timeout_race();
    apply_reset();
    set_a(0, 1, 0, 16'h0050, 24'h123456);
    set_a(1, 1, 1, 16'h0060, 24'h654321);
    cyc();
    cyc();
    set_a(0, 0, 0, 16'h0, 24'h0);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      n_cmp++;
      if (ifa.timeout_pulse !== 1'b0) begin
        n_err++; $display("FAIL race_stall%0d: got pulse %b want 0", k, ifa.timeout_pulse);
      end
    end
    set_a(0, 1, 0, 16'h0051, 24'h123457);
    cyc();
    n_cmp++;
    if (ifa.ctrl_en !== 8'hFF || ifa.ctrl_addr !== 16'h0051 || ifa.timeout_pulse !== 1'b0 ||
        ifa.busy !== 1'b1 || ifa.grant_id !== 2'd0) begin
      n_err++; $display("FAIL race_accept: got en %h addr %h pulse %b busy %b id %0d want ff 0051 0 1 0",
                        ifa.ctrl_en, ifa.ctrl_addr, ifa.timeout_pulse, ifa.busy, ifa.grant_id);
    end
    set_a(0, 0, 0, 16'h0, 24'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_cmp++;
      if (ifa.timeout_pulse !== (k == 8)) begin
        n_err++; $display("FAIL race_restall%0d: got pulse %b want %b", k, ifa.timeout_pulse, (k == 8));
      end
    end
    clr_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_a(0, 1, 1, 16'h0070, 24'hABCDEF);
    cyc();
    cyc();
    set_a(0, 1, 0, 16'h0071, 24'hABCDEF);
    cyc();
    cyc();
    n_cmp++;
    if (ifa.ctrl_en !== 8'hFF || ifa.ctrl_addr !== 16'h0071) begin
      n_err++; $display("FAIL rmid_beat: got en %h addr %h want ff 0071", ifa.ctrl_en, ifa.ctrl_addr);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (ifa.ctrl_en !== 8'h00 || ifa.ctrl_addr !== 16'h0 || ifa.busy !== 1'b0 || ifa.req_ready !== 3'b000) begin
      n_err++; $display("FAIL rmid_clear: got en %h addr %h busy %b ready %b want 00 0000 0 000",
                        ifa.ctrl_en, ifa.ctrl_addr, ifa.busy, ifa.req_ready);
    end
    set_a(1, 1, 1, 16'h0080, 24'h111111);
    cyc();
    cyc();
    resetn = 1'b1;
    n_cmp++;
    if (ifa.busy !== 1'b0 || ifa.grant_id !== 2'd0) begin
      n_err++; $display("FAIL rmid_idle: got busy %b id %0d want 0 0", ifa.busy, ifa.grant_id);
    end
    cyc();
    n_cmp++;
    if (ifa.grant_id !== 2'd0 || ifa.req_ready !== 3'b001) begin
      n_err++; $display("FAIL rmid_rrptr: got id %0d ready %b want 0 001", ifa.grant_id, ifa.req_ready);
    end
    clr_inputs();
  endtask

  task automatic test_random();
    int mowner, rr, bursts, n;
    int streak[3];
    logic [2:0] v_prev, vnow, exp_rdy;
    bit prev_idle, last_acc, exp_vld;
    beat_t exp_b, hb;
    logic [51:0] exp_ctrl;
    apply_reset();
    for (int i = 0; i < 3; i++) begin rq[i].delete(); streak[i] = 0; end
    mowner = -1; rr = 0; bursts = 0; v_prev = '0; vnow = '0;
    prev_idle = 1'b1; last_acc = 1'b0; exp_vld = 1'b0; exp_b = '0;
    for (int t = 0; t < 800; t++) begin
      if (last_acc) begin
        rr = (mowner + 1) % 3;
        mowner = -1;
        bursts++;
      end else if (prev_idle && v_prev != 3'b000) begin
        mowner = rr_choose(v_prev, rr);
      end
      n_cmp++;
      if (ifa.busy !== (mowner >= 0)) begin
        n_err++; $display("FAIL rnd_busy t=%0d: got %b want %b", t, ifa.busy, (mowner >= 0));
      end
      exp_rdy = (mowner >= 0) ? 3'(1 << mowner) : 3'b000;
      n_cmp++;
      if (ifa.req_ready !== exp_rdy) begin
        n_err++; $display("FAIL rnd_ready t=%0d: got %b want %b", t, ifa.req_ready, exp_rdy);
      end
      if (mowner >= 0) begin
        n_cmp++;
        if (ifa.grant_id !== 2'(mowner)) begin
          n_err++; $display("FAIL rnd_grant t=%0d: got %0d want %0d", t, ifa.grant_id, mowner);
        end
      end
      exp_ctrl = exp_vld ? {exp_b.en, exp_b.wr, exp_b.a, exp_b.d} : 52'h0;
      n_cmp++;
      if ({ifa.ctrl_en, ifa.ctrl_wr, ifa.ctrl_addr, ifa.ctrl_wdat} !== exp_ctrl) begin
        n_err++; $display("FAIL rnd_ctrl t=%0d: got %h want %h", t,
                          {ifa.ctrl_en, ifa.ctrl_wr, ifa.ctrl_addr, ifa.ctrl_wdat}, exp_ctrl);
      end
      n_cmp++;
      if (ifa.timeout_pulse !== 1'b0) begin
        n_err++; $display("FAIL rnd_timeout t=%0d: got 1 want 0", t);
      end
      prev_idle = (mowner < 0);
      for (int i = 0; i < 3; i++) begin
        if (rq[i].size() == 0 && $urandom_range(3) == 0) begin
          n = $urandom_range(1, 4);
          for (int b = 0; b < n; b++)
            rq[i].push_back('{en: 8'($urandom), wr: 4'($urandom), a: 16'($urandom),
                              d: 24'($urandom), l: (b == n - 1)});
        end
        if (rq[i].size() > 0) begin
          hb = rq[i][0];
          vnow[i] = (streak[i] >= 3) || ($urandom_range(9) < 6);
        end else begin
          hb = '0;
          vnow[i] = 1'b0;
        end
        streak[i] = (rq[i].size() > 0 && !vnow[i]) ? streak[i] + 1 : 0;
        ifa.req_valid[i] = vnow[i];
        ifa.req_last[i]  = hb.l;
        ifa.req_en[i*8 +: 8]     = hb.en;
        ifa.req_wr[i*4 +: 4]     = hb.wr;
        ifa.req_addr[i*16 +: 16] = hb.a;
        ifa.req_wdat[i*24 +: 24] = hb.d;
      end
      if (mowner >= 0 && vnow[mowner]) begin
        exp_b    = rq[mowner].pop_front();
        exp_vld  = 1'b1;
        last_acc = exp_b.l;
      end else begin
        exp_vld  = 1'b0;
        last_acc = 1'b0;
      end
      v_prev = vnow;
      cyc();
    end
    n_cmp++;
    if (bursts < 20) begin
      n_err++; $display("FAIL rnd_bursts: got %0d bursts want at least 20", bursts);
    end
    clr_inputs();
  endtask

  initial begin
    resetn = 1'b0;
    clr_inputs();
    test_reset();
    test_burst();
    test_alternation();
    test_gap();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
